// File: rtl/fifo_wptr_ctrl.sv
// fifo_wptr_ctrl
// Write-side pointer controller for a dual-clock FIFO, living entirely in the
// write clock domain. Keeps the binary write pointer, publishes its Gray copy
// to the read domain, and derives full / prog_full / fill level from the read
// Gray pointer (already synchronized into clk). Write requests are gated so the
// RAM is never overwritten.
//
// Ports
//   clk          write-domain clock
//   reset        synchronous, active-high reset
//   wr_en        producer write request
//   rd_gray_sync read pointer (Gray, AW+1 bits) synchronized to clk
//   clear_ovf    clears the sticky overflow flag
//   wr_accept    write accepted this cycle (combinational)
//   wr_addr      RAM write address (low AW bits of binary write pointer)
//   wr_gray      registered Gray write pointer for the read domain
//   full         registered full flag
//   prog_full    registered, fill level >= PROG_FULL
//   wr_count     registered fill level, 0..2**AW
//   overflow     sticky, set when wr_en is seen while full

module fifo_wptr_ctrl #(
  parameter int unsigned AW        = 4,
  parameter int unsigned PROG_FULL = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW:0]   rd_gray_sync,
  input  logic          clear_ovf,
  output logic          wr_accept,
  output logic [AW-1:0] wr_addr,
  output logic [AW:0]   wr_gray,
  output logic          full,
  output logic          prog_full,
  output logic [AW:0]   wr_count,
  output logic          overflow
);

  localparam logic [AW:0] PF_THR = PROG_FULL[AW:0];

  logic [AW:0] wr_bin_q,   wr_bin_d;
  logic [AW:0] wr_gray_q,  wr_gray_d;
  logic [AW:0] wr_count_q, wr_count_d;
  logic        full_q,     full_d;
  logic        prog_full_q, prog_full_d;
  logic        overflow_q, overflow_d;

  logic [AW:0] rd_bin;
  logic [AW:0] rd_gray_plus_depth;

  assign wr_accept = wr_en & ~full_q & ~reset;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin = '0;
    for (int unsigned i = 0; i <= AW; i++) begin
      rd_bin[i] = ^(rd_gray_sync >> i);
    end
  end

  // Gray code of (read pointer + depth): the top two Gray bits invert.
  assign rd_gray_plus_depth = {~rd_gray_sync[AW:AW-1], rd_gray_sync[AW-2:0]};

  always_comb begin
    wr_bin_d    = wr_bin_q + {{AW{1'b0}}, wr_accept};
    wr_gray_d   = wr_bin_d ^ (wr_bin_d >> 1);
    // Compared against the next pointer so full rises on the filling edge.
    full_d      = (wr_gray_d == rd_gray_plus_depth);
    wr_count_d  = wr_bin_d - rd_bin;
    prog_full_d = (wr_count_d >= PF_THR);
    overflow_d  = overflow_q;
    if (clear_ovf) overflow_d = 1'b0;
    if (wr_en && full_q) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bin_q    <= '0;
      wr_gray_q   <= '0;
      wr_count_q  <= '0;
      full_q      <= 1'b0;
      prog_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_bin_q    <= wr_bin_d;
      wr_gray_q   <= wr_gray_d;
      wr_count_q  <= wr_count_d;
      full_q      <= full_d;
      prog_full_q <= prog_full_d;
      overflow_q  <= overflow_d;
    end
  end

  assign wr_addr   = wr_bin_q[AW-1:0];
  assign wr_gray   = wr_gray_q;
  assign full      = full_q;
  assign prog_full = prog_full_q;
  assign wr_count  = wr_count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
module tb_fifo_wptr_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] rd_gray_sync = '0;
  logic       clear_ovf = 1'b0;
  logic       wr_accept;
  logic [3:0] wr_addr;
  logic [4:0] wr_gray;
  logic       full;
  logic       prog_full;
  logic [4:0] wr_count;
  logic       overflow;

  fifo_wptr_ctrl #(.AW(4), .PROG_FULL(12)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_gray_sync(rd_gray_sync),
    .clear_ovf(clear_ovf), .wr_accept(wr_accept), .wr_addr(wr_addr),
    .wr_gray(wr_gray), .full(full), .prog_full(prog_full),
    .wr_count(wr_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: unbounded pointers, fill level = difference.
  int   wptr = 0;
  int   rptr = 0;
  logic exp_full = 1'b0, exp_pf = 1'b0, exp_ovf = 1'b0, exp_acc = 1'b0;
  int   exp_count = 0;
  logic [4:0] prev_gray;

  logic [4:0] gtbl [0:16] = '{5'h00, 5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04,
                              5'h0C, 5'h0D, 5'h0F, 5'h0E, 5'h0A, 5'h0B, 5'h09, 5'h08, 5'h18};

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, check accept/addr, clock, check registered outputs.
  task automatic step(input logic we, input logic clr, input logic rst);
    logic ovf_set;
    int   cnt;
    if (rst) rptr = 0;
    wr_en = we; clear_ovf = clr; reset = rst; rd_gray_sync = gray5(rptr);
    #1;
    exp_acc = we && !exp_full && !rst;
    chk("wr_accept", {31'd0, wr_accept}, {31'd0, exp_acc});
    if (!rst) chk("wr_addr", {28'd0, wr_addr}, wptr % 16);
    prev_gray = wr_gray;
    @(posedge clk);
    if (rst) begin
      wptr = 0; exp_full = 0; exp_pf = 0; exp_ovf = 0; exp_count = 0;
    end else begin
      ovf_set = we && exp_full;
      if (exp_acc) wptr++;
      cnt = wptr - rptr;
      exp_count = cnt;
      exp_full  = (cnt == 16);
      exp_pf    = (cnt >= 12);
      if (ovf_set) exp_ovf = 1'b1;
      else if (clr) exp_ovf = 1'b0;
    end
    @(negedge clk);
    chk("wr_gray",   {27'd0, wr_gray},   {27'd0, gray5(wptr)});
    chk("wr_count",  {27'd0, wr_count},  exp_count);
    chk("full",      {31'd0, full},      {31'd0, exp_full});
    chk("prog_full", {31'd0, prog_full}, {31'd0, exp_pf});
    chk("overflow",  {31'd0, overflow},  {31'd0, exp_ovf});
    if (!rst) chk("gray_hamming", $countones(wr_gray ^ prev_gray), exp_acc ? 1 : 0);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_gray", {27'd0, wr_gray}, 0);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_count", {27'd0, wr_count}, 0);

    // Test 1: sixteen writes into an empty FIFO
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("t1_gray_seq", {27'd0, wr_gray}, {27'd0, gtbl[k]});
      if (k == 11) chk("t1_pf_before", {31'd0, prog_full}, 0);
      if (k == 12) chk("t1_pf_at12", {31'd0, prog_full}, 1);
      if (k == 15) chk("t1_full_before", {31'd0, full}, 0);
    end
    chk("t1_full", {31'd0, full}, 1);
    chk("t1_count16", {27'd0, wr_count}, 16);

    // Test 2: writes while full are refused and flag overflow
    repeat (3) step(1'b1, 1'b0, 1'b0);
    chk("t2_gray_hold", {27'd0, wr_gray}, 32'h18);
    chk("t2_ovf", {31'd0, overflow}, 1);
    step(1'b1, 1'b1, 1'b0);
    chk("t2_ovf_setwins", {31'd0, overflow}, 1);
    step(1'b0, 1'b1, 1'b0);
    chk("t2_ovf_clr", {31'd0, overflow}, 0);

    // Test 3: read pointer jumps to 4 (Gray 0x06)
    rptr = 4;
    step(1'b0, 1'b0, 1'b0);
    chk("t3_rdgray", {27'd0, rd_gray_sync}, 32'h06);
    chk("t3_full", {31'd0, full}, 0);
    chk("t3_count", {27'd0, wr_count}, 12);
    chk("t3_pf", {31'd0, prog_full}, 1);
    step(1'b1, 1'b0, 1'b0);
    chk("t3_count13", {27'd0, wr_count}, 13);

    // Test 4: read trails write by two, 40 writes through the wrap
    step(1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 40; n++) begin
      rptr = (wptr >= 2) ? wptr - 2 : 0;
      step(1'b1, 1'b0, 1'b0);
      if (wptr == 31) chk("t4_gray31", {27'd0, wr_gray}, 32'h10);
      if (wptr == 32) chk("t4_gray_wrap", {27'd0, wr_gray}, 32'h00);
    end
    chk("t4_gray40", {27'd0, wr_gray}, 32'h0C);
    chk("t4_nofull", {31'd0, full}, 0);

    // Test 5: fill, overflow, then reset while full
    repeat (20) step(1'b1, 1'b0, 1'b0);
    chk("t5_full", {31'd0, full}, 1);
    chk("t5_ovf", {31'd0, overflow}, 1);
    step(1'b1, 1'b0, 1'b1);
    chk("t5_gray0", {27'd0, wr_gray}, 0);
    chk("t5_full0", {31'd0, full}, 0);
    chk("t5_pf0", {31'd0, prog_full}, 0);
    chk("t5_count0", {27'd0, wr_count}, 0);
    chk("t5_ovf0", {31'd0, overflow}, 0);

    // Test 6: random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (rptr < wptr && $urandom_range(0, 1) == 1) rptr++;
      step($urandom_range(0, 99) < 60, $urandom_range(0, 15) == 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
